// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - stored note-code sequencer driving the tone decoder input
// Optional inter-note silence is enabled by defining TONE_SEQ_GAP_EN.
module tone_sequencer #(
  parameter int DEPTH       = 32,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [3:0]               wr_num,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     abort,
  output logic [3:0]               num,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CNTW   = AW + 1;
  localparam int CW_RAW = $clog2(NOTE_CYCLES > GAP_CYCLES ? NOTE_CYCLES : GAP_CYCLES);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
  localparam logic [CW-1:0]   NOTE_LAST = CW'(NOTE_CYCLES - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(DEPTH);
`ifdef TONE_SEQ_GAP_EN
  localparam logic [CW-1:0]   GAP_LAST  = CW'(GAP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1
`ifdef TONE_SEQ_GAP_EN
    , S_GAP = 2'd2
`endif
  } state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   idx, idx_nx;
  logic [CW-1:0]   dcnt, dcnt_nx;
  logic [CNTW-1:0] count_nx;
  logic [3:0]      num_nx;
  logic            busy_nx, done_nx;
  logic [3:0]      mem [DEPTH];

  logic            wr_ok;
  logic [AW-1:0]   wr_idx;
  logic [CNTW-1:0] eff_count;
  logic            has_next;

  // A write is accepted only while idle, not clearing, and with room left
  assign wr_idx    = count[AW-1:0];
  assign wr_ok     = (state == S_IDLE) && wr_en && !clear && (count != FULL);
  assign eff_count = clear ? '0 : count + {{AW{1'b0}}, wr_ok};
  assign has_next  = ({1'b0, idx} + CNTW'(1)) < count;

  // Note storage; contents need no reset because count defines validity
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_num;
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
      dcnt  <= '0;
      count <= '0;
      num   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      dcnt  <= dcnt_nx;
      count <= count_nx;
      num   <= num_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  // Next-state, read index, duration counter and note count
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    dcnt_nx  = dcnt + CW'(1);
    count_nx = count;
    case (state)
      S_IDLE: begin
        dcnt_nx = '0;
        if (clear)      count_nx = '0;
        else if (wr_ok) count_nx = count + CNTW'(1);
        if (start) begin
          idx_nx = '0;
          if (eff_count != '0) state_nx = S_PLAY;
        end
      end
      S_PLAY: begin
        if (abort) begin
          state_nx = S_IDLE;
          dcnt_nx  = '0;
        end else if (dcnt == NOTE_LAST) begin
          dcnt_nx = '0;
`ifdef TONE_SEQ_GAP_EN
          state_nx = S_GAP;
`else
          if (has_next) idx_nx = idx + AW'(1);
          else          state_nx = S_IDLE;
`endif
        end
      end
`ifdef TONE_SEQ_GAP_EN
      S_GAP: begin
        if (abort) begin
          state_nx = S_IDLE;
          dcnt_nx  = '0;
        end else if (dcnt == GAP_LAST) begin
          dcnt_nx = '0;
          if (has_next) begin
            idx_nx   = idx + AW'(1);
            state_nx = S_PLAY;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
        dcnt_nx  = '0;
      end
    endcase
  end

  // Output values for the next cycle; a same-cycle write to entry 0 is forwarded
  always_comb begin
    num_nx  = 4'd0;
    busy_nx = (state_nx != S_IDLE);
    done_nx = 1'b0;
    if (state_nx == S_PLAY) begin
      num_nx = (wr_ok && (wr_idx == idx_nx)) ? wr_num : mem[idx_nx];
    end
    if (state == S_IDLE) begin
      done_nx = start && (eff_count == '0);
    end else begin
      done_nx = (state_nx == S_IDLE) && !abort;
    end
  end

endmodule
